// File: rtl/crc_stream_enc.sv
// Multi-beat streaming CRC encoder: a one-stage valid/ready register slice that
// carries a running CRC across the beats of a packet and emits it with the last beat.
module crc_stream_enc #(
  parameter int                   DATA_WIDTH = 512,
  parameter int                   CRC_WIDTH  = 32,
  parameter logic [CRC_WIDTH-1:0] POLY       = 32'h04C11DB7,
  parameter logic [CRC_WIDTH-1:0] INIT       = 32'hFFFFFFFF,
  parameter logic [CRC_WIDTH-1:0] XOR_OUT    = 32'hFFFFFFFF,
  parameter int                   MAX_BEATS  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  last_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  last_o,
  output logic [CRC_WIDTH-1:0]  checksum_o,
  output logic                  err_o
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  // Bit-serial, MSB-first, non-reflected CRC over one full beat.
  function automatic logic [CRC_WIDTH-1:0] crc_beat(input logic [CRC_WIDTH-1:0] crc_in,
                                                    input logic [DATA_WIDTH-1:0] data);
    logic [CRC_WIDTH-1:0] c;
    logic                 fb;
    c = crc_in;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      fb = c[CRC_WIDTH-1] ^ data[i];
      c  = {c[CRC_WIDTH-2:0], 1'b0};
      if (fb) c = c ^ POLY;
    end
    return c;
  endfunction

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  last_q, last_d;
  logic                  err_q, err_d;
  logic [CRC_WIDTH-1:0]  chk_q, chk_d;
  logic [CRC_WIDTH-1:0]  crc_q, crc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  first_q, first_d;

  logic                  accept;
  logic                  at_max;
  logic                  final_beat;
  logic [CRC_WIDTH-1:0]  crc_cur;
  logic [CRC_WIDTH-1:0]  crc_nxt;

  assign ready_o = !valid_q || ready_i;
  assign accept  = valid_i && ready_o;

  always_comb begin
    valid_d    = valid_q;
    data_d     = data_q;
    last_d     = last_q;
    err_d      = err_q;
    chk_d      = chk_q;
    crc_d      = crc_q;
    cnt_d      = cnt_q;
    first_d    = first_q;

    crc_cur    = first_q ? INIT : crc_q;
    crc_nxt    = crc_beat(crc_cur, data_i);
    // cnt_q counts beats already taken, so this beat is number MAX_BEATS
    at_max     = (cnt_q == CNT_W'(MAX_BEATS - 1));
    final_beat = last_i || at_max;

    if (accept) begin
      valid_d = 1'b1;
      data_d  = data_i;
      last_d  = final_beat;
      err_d   = at_max && !last_i;
      if (final_beat) begin
        chk_d   = crc_nxt ^ XOR_OUT;
        crc_d   = INIT;
        cnt_d   = '0;
        first_d = 1'b1;
      end else begin
        chk_d   = '0;
        crc_d   = crc_nxt;
        cnt_d   = cnt_q + CNT_W'(1);
        first_d = 1'b0;
      end
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      chk_q   <= '0;
      crc_q   <= INIT;
      cnt_q   <= '0;
      first_q <= 1'b1;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      err_q   <= err_d;
      chk_q   <= chk_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

  assign valid_o    = valid_q;
  assign data_o     = data_q;
  assign last_o     = last_q;
  assign checksum_o = (valid_q && last_q) ? chk_q : '0;
  assign err_o      = valid_q && last_q && err_q;

endmodule
